// File: rtl/support_seq.sv
// Board reset/boot sequencer with front-panel button conditioning.
// A step-tick FSM walks clock-manager reset, memory reset, calibration wait,
// CPU reset and boot. Four debounced buttons request cold restart, warm boot,
// halt toggle and an interrupt pulse. All outputs are registered.
module support_seq #(
  parameter int STEP_DIV     = 64,
  parameter int DEB_DIV      = 4096,
  parameter int DEB_LEN      = 10,
  parameter int HOLDOFF      = 4,
  parameter int MEMRST_STEPS = 2,
  parameter int CAL_TIMEOUT  = 1024,
  parameter int CPURST_STEPS = 3,
  parameter int BOOT_STEPS   = 1
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       button_r,
  input  logic       button_b,
  input  logic       button_h,
  input  logic       button_c,
  input  logic       mem_calib_done,
  output logic       clk_reset,
  output logic       mem_reset,
  output logic       reset,
  output logic       boot,
  output logic       halt,
  output logic       interrupt,
  output logic       fault,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_MEMRST  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CALWAIT = 3'd3,
    ST_CPURST  = 3'd4,
    ST_BOOT    = 3'd5,
    ST_RUN     = 3'd6,
    ST_FAULT   = 3'd7
  } state_t;

  localparam int SW = $clog2(STEP_DIV);
  localparam int DDW = $clog2(DEB_DIV);
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam int MAX_A = (MEMRST_STEPS > CPURST_STEPS) ? MEMRST_STEPS : CPURST_STEPS;
  localparam int MAX_B = (CAL_TIMEOUT > BOOT_STEPS) ? CAL_TIMEOUT : BOOT_STEPS;
  localparam int DWELL_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int DW = $clog2(DWELL_MAX + 1);

  localparam logic [SW-1:0]  STEP_LAST   = SW'(STEP_DIV - 1);
  localparam logic [DDW-1:0] DEB_LAST    = DDW'(DEB_DIV - 1);
  localparam logic [HW-1:0]  HOLD_LAST   = HW'(HOLDOFF);
  localparam logic [DW-1:0]  DWELL_SAT   = DW'(DWELL_MAX);
  localparam logic [DW-1:0]  MEMRST_LAST = DW'(MEMRST_STEPS - 1);
  localparam logic [DW-1:0]  CAL_LAST    = DW'(CAL_TIMEOUT - 1);
  localparam logic [DW-1:0]  CPURST_LAST = DW'(CPURST_STEPS - 1);
  localparam logic [DW-1:0]  BOOT_LAST   = DW'(BOOT_STEPS - 1);

  logic [SW-1:0]  step_cnt_q;
  logic [DDW-1:0] deb_cnt_q;
  logic [HW-1:0]  holdoff_q, holdoff_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  state_t         state_q, state_d;
  logic           r_pend_q, r_pend_d, b_pend_q, b_pend_d;
  logic           halt_q, halt_d;
  logic           clk_reset_q, mem_reset_q, reset_q, boot_q, interrupt_q, fault_q;
  logic           step_tick_w, deb_tick_w;
  logic [3:0]     btn_w, press_w;

  assign step_tick_w = (step_cnt_q == STEP_LAST);
  assign deb_tick_w  = (deb_cnt_q == DEB_LAST);
  assign holdoff_d   = (holdoff_q == HOLD_LAST) ? holdoff_q : holdoff_q + 1'b1;

  // Free-running step and debounce dividers plus the post-reset holdoff counter
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt_q <= '0;
      deb_cnt_q  <= '0;
      holdoff_q  <= '0;
    end else begin
      step_cnt_q <= step_tick_w ? '0 : step_cnt_q + 1'b1;
      deb_cnt_q  <= deb_tick_w ? '0 : deb_cnt_q + 1'b1;
      holdoff_q  <= holdoff_d;
    end
  end

  // Button order: 0 = restart, 1 = warm boot, 2 = halt, 3 = interrupt
  assign btn_w = {button_c, button_h, button_b, button_r};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_deb
      logic [DEB_LEN-1:0] hist_q, hist_d;
      assign hist_d = (hist_q << 1) | DEB_LEN'(btn_w[gi]);
      // Press fires on the tick where the history first becomes all ones
      assign press_w[gi] = deb_tick_w & (&hist_d) & ~(&hist_q);
      // Shift in one pin sample per debounce tick
      always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) hist_q <= '0;
        else if (deb_tick_w) hist_q <= hist_d;
      end
    end
  endgenerate

  // Next state, restart latches and halt; transitions only on step ticks
  always_comb begin
    state_d  = state_q;
    r_pend_d = r_pend_q;
    b_pend_d = b_pend_q;
    halt_d   = halt_q;
    if (press_w[0] && (state_q == ST_RUN || state_q == ST_FAULT)) r_pend_d = 1'b1;
    if (press_w[1] && state_q == ST_RUN) b_pend_d = 1'b1;
    if (press_w[2] && state_q == ST_RUN) halt_d = ~halt_q;
    if (step_tick_w) begin
      case (state_q)
        ST_INIT:    state_d = ST_MEMRST;
        ST_MEMRST:  if (dwell_q == MEMRST_LAST) state_d = ST_SETTLE;
        ST_SETTLE:  state_d = ST_CALWAIT;
        ST_CALWAIT: begin
          // A completed calibration beats a timeout on the same tick
          if (mem_calib_done) state_d = ST_CPURST;
          else if (dwell_q == CAL_LAST) state_d = ST_FAULT;
        end
        ST_CPURST:  if (dwell_q == CPURST_LAST) state_d = ST_CPURST + 3'd1 == ST_BOOT ? ST_BOOT : ST_BOOT;
        ST_BOOT:    if (dwell_q == BOOT_LAST) state_d = ST_RUN;
        ST_RUN: begin
          if (r_pend_q) state_d = ST_MEMRST;
          else if (b_pend_q) state_d = ST_CPURST;
        end
        ST_FAULT:   if (r_pend_q) state_d = ST_MEMRST;
        default:    state_d = ST_INIT;
      endcase
    end
    if (state_d != state_q) begin
      r_pend_d = 1'b0;
      b_pend_d = 1'b0;
      if (state_d == ST_CPURST || state_d == ST_MEMRST) halt_d = 1'b0;
    end
    if (state_d != state_q) dwell_d = '0;
    else if (step_tick_w && dwell_q != DWELL_SAT) dwell_d = dwell_q + 1'b1;
    else dwell_d = dwell_q;
  end

  // Sequencer state plus outputs decoded from the next state so they track it
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      dwell_q     <= '0;
      r_pend_q    <= 1'b0;
      b_pend_q    <= 1'b0;
      halt_q      <= 1'b0;
      clk_reset_q <= 1'b1;
      mem_reset_q <= 1'b0;
      reset_q     <= 1'b1;
      boot_q      <= 1'b0;
      interrupt_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      r_pend_q    <= r_pend_d;
      b_pend_q    <= b_pend_d;
      halt_q      <= halt_d;
      clk_reset_q <= (state_d == ST_INIT);
      mem_reset_q <= (state_d == ST_INIT || state_d == ST_MEMRST) && (holdoff_d == HOLD_LAST);
      reset_q     <= !(state_d == ST_BOOT || state_d == ST_RUN);
      boot_q      <= (state_d == ST_BOOT);
      interrupt_q <= press_w[3] && (state_q == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign clk_reset = clk_reset_q;
  assign mem_reset = mem_reset_q;
  assign reset     = reset_q;
  assign boot      = boot_q;
  assign halt      = halt_q;
  assign interrupt = interrupt_q;
  assign fault     = fault_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_support_seq.sv
// Directed bench for support_seq using small divider settings.
module tb_support_seq;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       button_r = 1'b0, button_b = 1'b0, button_h = 1'b0, button_c = 1'b0;
  logic       mem_calib_done = 1'b1;
  logic       clk_reset, mem_reset, reset, boot, halt, interrupt, fault;
  logic [2:0] seq_state;

  int tests_run = 0;
  int tests_failed = 0;
  int trans[$];
  logic [2:0] last_st;
  int int_cnt, stray_clk, stray_mem;

  support_seq #(
    .STEP_DIV(4), .DEB_DIV(2), .DEB_LEN(3), .HOLDOFF(4),
    .MEMRST_STEPS(2), .CAL_TIMEOUT(5), .CPURST_STEPS(3), .BOOT_STEPS(1)
  ) dut (
    .sysclk(sysclk), .reset_n(reset_n),
    .button_r(button_r), .button_b(button_b), .button_h(button_h), .button_c(button_c),
    .mem_calib_done(mem_calib_done),
    .clk_reset(clk_reset), .mem_reset(mem_reset), .reset(reset), .boot(boot),
    .halt(halt), .interrupt(interrupt), .fault(fault), .seq_state(seq_state)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the first negedge showing state st, within a cycle budget
  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (seq_state !== st && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    check(32'(seq_state), 32'(st), tag);
  endtask

  // Count cycles spent in st (called at its first cycle) and verify outputs
  task automatic dwell(input logic [2:0] st, input int cyc, input logic ecr,
                       input logic em, input string tag);
    int n = 0;
    int bad = 0;
    while (seq_state === st && n < 100) begin
      if (clk_reset !== ecr || mem_reset !== em ||
          reset !== ((st < 3'd5) || (st == 3'd7)) ||
          boot !== (st == 3'd5) || fault !== (st == 3'd7)) bad++;
      n++;
      @(negedge sysclk);
    end
    check(32'(n), 32'(cyc), tag);
    check(32'(bad), 32'd0, {tag, "_outs"});
  endtask

  task automatic watch_clear();
    trans.delete();
    last_st = seq_state;
    int_cnt = 0;
    stray_clk = 0;
    stray_mem = 0;
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      @(negedge sysclk);
      if (seq_state !== last_st) begin
        trans.push_back(int'(seq_state));
        last_st = seq_state;
      end
      if (interrupt === 1'b1) int_cnt++;
      if (clk_reset === 1'b1) stray_clk++;
      if (mem_reset === 1'b1) stray_mem++;
    end
  endtask

  function automatic int trans_code();
    int code = 0;
    foreach (trans[i]) code = code * 10 + trans[i];
    return code;
  endfunction

  initial begin
    // Reset values
    repeat (3) @(negedge sysclk);
    check(32'(seq_state), 0, "rst_state");
    check(32'(clk_reset), 1, "rst_clk_reset");
    check(32'(mem_reset), 0, "rst_mem_reset");
    check(32'(reset), 1, "rst_reset");
    check(32'(boot), 0, "rst_boot");
    check(32'(halt), 0, "rst_halt");
    check(32'(interrupt), 0, "rst_interrupt");
    check(32'(fault), 0, "rst_fault");
    $display("[TB] reset values checked");

    // Power-up walk with calibration already done
    reset_n = 1'b1;
    @(negedge sysclk);
    dwell(3'd0, 3, 1'b1, 1'b0, "pu_init");
    dwell(3'd1, 8, 1'b0, 1'b1, "pu_memrst");
    dwell(3'd2, 4, 1'b0, 1'b0, "pu_settle");
    dwell(3'd3, 4, 1'b0, 1'b0, "pu_calwait");
    dwell(3'd4, 12, 1'b0, 1'b0, "pu_cpurst");
    dwell(3'd5, 4, 1'b0, 1'b0, "pu_boot");
    check(32'(seq_state), 6, "pu_run");
    check(32'(reset), 0, "pu_run_reset");
    $display("[TB] power-up sequence to RUN");

    // Halt toggles twice, interrupt pulses once
    watch_clear(); button_h = 1'b1; watch(6); button_h = 1'b0; watch(4);
    check(32'(halt), 1, "halt_on");
    check(32'(int_cnt), 0, "halt_no_int");
    watch_clear(); button_h = 1'b1; watch(6); button_h = 1'b0; watch(4);
    check(32'(halt), 0, "halt_off");
    watch_clear(); button_c = 1'b1; watch(6); button_c = 1'b0; watch(4);
    check(32'(int_cnt), 1, "int_pulse_width");
    check(32'(trans.size()), 0, "int_no_state_change");
    $display("[TB] halt toggle and interrupt pulse");

    // Warm boot with halt set and the button held well beyond the press
    watch_clear(); button_h = 1'b1; watch(6); button_h = 1'b0; watch(4);
    check(32'(halt), 1, "wb_halt_set");
    watch_clear(); button_b = 1'b1; watch(60); button_b = 1'b0; watch(4);
    check(32'(trans_code()), 456, "wb_sequence");
    check(32'(stray_clk), 0, "wb_clk_reset_low");
    check(32'(stray_mem), 0, "wb_mem_reset_low");
    check(32'(halt), 0, "wb_halt_cleared");
    $display("[TB] warm boot");

    // Bouncy restart button must not restart
    watch_clear();
    button_r = 1'b1; watch(4); button_r = 1'b0; watch(2);
    button_r = 1'b1; watch(4); button_r = 1'b0; watch(20);
    check(32'(trans.size()), 0, "bounce_no_restart");
    check(32'(seq_state), 6, "bounce_still_run");
    $display("[TB] debounce rejection");

    // Restart and warm boot on the same tick: restart wins
    watch_clear();
    button_r = 1'b1; button_b = 1'b1; watch(6);
    button_r = 1'b0; button_b = 1'b0; watch(60);
    check(32'(trans_code()), 123456, "conflict_sequence");
    check(32'(stray_clk), 0, "conflict_clk_reset_low");
    $display("[TB] same-tick conflict");

    // Halt and interrupt presses during CPURST have no effect
    button_b = 1'b1;
    wait_state(3'd4, 30, "hc_enter_cpurst");
    button_b = 1'b0;
    watch_clear(); button_h = 1'b1; button_c = 1'b1; watch(6);
    button_h = 1'b0; button_c = 1'b0;
    check(32'(seq_state), 4, "hc_still_cpurst");
    watch(2);
    check(32'(halt), 0, "hc_halt_ignored");
    check(32'(int_cnt), 0, "hc_int_ignored");
    wait_state(3'd6, 40, "hc_back_run");
    $display("[TB] halt/interrupt ignored in CPURST");

    // Calibration timeout into FAULT
    mem_calib_done = 1'b0;
    button_r = 1'b1;
    wait_state(3'd1, 30, "to_enter_memrst");
    button_r = 1'b0;
    dwell(3'd1, 8, 1'b0, 1'b1, "to_memrst");
    dwell(3'd2, 4, 1'b0, 1'b0, "to_settle");
    dwell(3'd3, 20, 1'b0, 1'b0, "to_calwait");
    check(32'(seq_state), 7, "to_fault_state");
    check(32'(fault), 1, "to_fault_flag");
    check(32'(reset), 1, "to_fault_reset");
    watch_clear(); button_b = 1'b1; watch(6); button_b = 1'b0; watch(12);
    check(32'(trans.size()), 0, "fault_b_ignored");
    $display("[TB] calibration timeout");

    // Recovery from FAULT by restart
    mem_calib_done = 1'b1;
    button_r = 1'b1;
    wait_state(3'd1, 30, "rec_enter_memrst");
    button_r = 1'b0;
    check(32'(fault), 0, "rec_fault_cleared");
    dwell(3'd1, 8, 1'b0, 1'b1, "rec_memrst");
    dwell(3'd2, 4, 1'b0, 1'b0, "rec_settle");
    dwell(3'd3, 4, 1'b0, 1'b0, "rec_calwait");
    dwell(3'd4, 12, 1'b0, 1'b0, "rec_cpurst");
    dwell(3'd5, 4, 1'b0, 1'b0, "rec_boot");
    check(32'(seq_state), 6, "rec_run");
    $display("[TB] fault recovery");

    // Asynchronous reset during BOOT, checked between clock edges
    button_b = 1'b1;
    wait_state(3'd4, 30, "ar_enter_cpurst");
    button_b = 1'b0;
    wait_state(3'd5, 30, "ar_enter_boot");
    #1 reset_n = 1'b0;
    #1;
    check(32'(seq_state), 0, "ar_state");
    check(32'(clk_reset), 1, "ar_clk_reset");
    check(32'(mem_reset), 0, "ar_mem_reset");
    check(32'(reset), 1, "ar_reset");
    check(32'(boot), 0, "ar_boot");
    check(32'(halt), 0, "ar_halt");
    check(32'(fault), 0, "ar_fault");
    $display("[TB] async reset in BOOT");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/support_seq.md
Name: support_seq

Overview:
- Parametrised board-level reset/boot sequencer and front-panel button conditioner, all on one clock.
- Sequences the clock-manager reset, the memory-controller reset and calibration wait, CPU reset, and the boot strobe.
- Debounces four panel buttons:
  - cold restart (button_r)
  - warm boot (button_b)
  - halt toggle (button_h)
  - interrupt pulse (button_c)
- Adds a calibration timeout with a fault state.
- Sits at the top level between the board pins, the clock/memory IP and the CPU core.

Parameters:
- STEP_DIV, 64: sysclk cycles per sequencer step tick (≥2).
- DEB_DIV, 4096: sysclk cycles per debounce sample tick (≥2).
- DEB_LEN, 10: consecutive high samples that constitute a press (1..32).
- HOLDOFF, 4: sysclk cycles after reset_n release during which mem_reset is held low.
- MEMRST_STEPS, 2: steps spent in MEMRST.
- CAL_TIMEOUT, 1024: steps allowed in CALWAIT before FAULT.
- CPURST_STEPS, 3: steps in CPURST.
- BOOT_STEPS, 1: steps in BOOT.

Ports:
- sysclk, input, 1: sole clock.
- reset_n, input, 1: asynchronous active-low reset.
- button_r, input, 1: cold-restart button, active high, already synchronised.
- button_b, input, 1: warm-boot button.
- button_h, input, 1: halt-toggle button.
- button_c, input, 1: interrupt button.
- mem_calib_done, input, 1: memory controller calibration complete (level).
- clk_reset, output, 1: reset to clock manager.
- mem_reset, output, 1: reset to memory controller.
- reset, output, 1: CPU reset.
- boot, output, 1: CPU boot strobe (level, spans BOOT).
- halt, output, 1: CPU halt request (level).
- interrupt, output, 1: one-cycle interrupt pulse.
- fault, output, 1: calibration timeout flag.
- seq_state, output, 3: current state encoding, for debug.

Behaviour:
- Reset is asynchronous and active-low. reset_n low forces:
  - state INIT, all counters 0, debounce history 0
  - clk_reset=1, mem_reset=0, reset=1, boot=0, halt=0, interrupt=0, fault=0, seq_state=0
- Step tick:
  - Free-running counter 0..STEP_DIV-1; tick is the cycle where the count equals STEP_DIV-1.
  - All state transitions occur only on a tick cycle.
  - A dwell counter clears on every state entry and increments on each tick spent in the state.
- States and encodings:
  - INIT=0: clk_reset=1. Goes to MEMRST on the first tick.
  - MEMRST=1: mem_reset=1. Goes to SETTLE after MEMRST_STEPS ticks.
  - SETTLE=2: goes to CALWAIT after 1 tick.
  - CALWAIT=3: mem_calib_done is sampled on each tick.
    - High: go to CPURST.
    - Dwell reaches CAL_TIMEOUT: go to FAULT.
    - calib_done has priority over the timeout on the same tick.
  - CPURST=4: goes to BOOT after CPURST_STEPS ticks.
  - BOOT=5: boot=1. Goes to RUN after BOOT_STEPS ticks.
  - RUN=6: steady state.
  - FAULT=7: fault=1; reset stays 1.
- reset output:
  - 1 in states 0–4 and 7.
  - 0 in BOOT and RUN. The CPU leaves reset as boot rises.
- mem_reset:
  - 1 in INIT and MEMRST, but forced 0 while the holdoff counter (counts 0..HOLDOFF, saturating) is below HOLDOFF after reset_n release.
  - The holdoff is not re-armed by button restarts.
- Debounce:
  - Per button, a DEB_LEN-bit shift register samples the pin on each debounce tick.
  - "Detected" means all bits are 1.
  - A press event is detected AND NOT detected-on-previous-tick, so one event per press and a release is required before the next.
  - Events are single sysclk cycles, coincident with the debounce tick.
- Press actions:
  - button_r in RUN or FAULT: latched, then go to MEMRST on the next step tick. Clears fault. The clock manager is not reset.
  - button_b in RUN: latched, then go to CPURST on the next step tick.
  - button_b in FAULT: ignored.
  - Both latched at once: r wins; both latches clear on the transition.
  - Presses of r or b in any other state are discarded (not latched).
  - button_h: toggles halt in RUN only.
  - halt is cleared on entry to CPURST or MEMRST.
  - button_c: interrupt=1 for exactly the event cycle, in RUN only. It is not suppressed by halt.
- Outputs are registered. State-derived outputs change in the cycle after the tick.

Test Plan:
- Parameters for all scenarios: STEP_DIV=4, DEB_DIV=2, DEB_LEN=3, HOLDOFF=4, MEMRST_STEPS=2, CAL_TIMEOUT=5, CPURST_STEPS=3, BOOT_STEPS=1.
- Power-up: release reset_n with mem_calib_done=1.
  - Required: seq_state walks 0,1,2,3,4,5,6 with dwells of 1,2,1,1,3,1 steps.
  - Required: boot high for exactly 4 cycles, coincident with reset falling; clk_reset low after the first tick.
- Calibration timeout: hold mem_calib_done=0.
  - Required: FAULT entered after 5 CALWAIT ticks, fault=1, reset=1.
  - Then raise calib_done and press button_r: required MEMRST, fault=0, normal completion to RUN.
- Warm boot: in RUN, hold button_b high for 3 debounce ticks.
  - Required: state goes 6→4→5→6, clk_reset and mem_reset stay 0, halt is cleared.
  - Holding the button longer must not produce a second restart.
- Debounce rejection: button_r high for 2 ticks, low 1 tick, high 2 ticks.
  - Required: no restart.
- Same-tick conflict: button_r and button_b events on the same tick.
  - Required: MEMRST entered.
- Halt and interrupt:
  - button_h pressed twice in RUN: required halt goes 0→1→0.
  - button_c press: required interrupt high for exactly 1 cycle.
  - button_h or button_c pressed during CPURST: required no effect.
- Async reset mid-sequence: assert reset_n low during BOOT.
  - Required: outputs return to reset values within the same cycle, without a clock edge.
